// File: rtl/ahb_interconnect_decoder_if.sv
// rtl/ahb_interconnect_decoder_if.sv - AHB master-to-slaves bus bundle around the interconnect decoder
interface ahb_interconnect_decoder_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]            haddr;
    logic [1:0]                       htrans;
    logic [NUM_SLAVES-1:0]            hselx;
    logic                             hready;
    logic [NUM_SLAVES-1:0]            hreadyout_s;
    logic [NUM_SLAVES-1:0]            hresp_s;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s;
    logic [DATA_WIDTH-1:0]            hrdata;
    logic                             hresp;

    // The fabric side driving addresses and slave responses.
    modport master (
        output haddr, htrans, hreadyout_s, hresp_s, hrdata_s,
        input  hselx, hready, hrdata, hresp
    );

    // The interconnect itself.
    modport slave (
        input  haddr, htrans, hreadyout_s, hresp_s, hrdata_s,
        output hselx, hready, hrdata, hresp
    );
endinterface

// File: rtl/ahb_interconnect_decoder.sv
// rtl/ahb_interconnect_decoder.sv - AHB address decode, response mux and default slave; AHB_INTERCONNECT_TIMEOUT_EN adds a wait-state timeout
module ahb_interconnect_decoder #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SEL_W = $clog2(NUM_SLAVES) + 1
) (
    input  logic                 hclk,
    input  logic                 hresetn,
`ifdef AHB_INTERCONNECT_TIMEOUT_EN
    output logic                 timeout_flag,
    output logic [SEL_W-1:0]     timeout_slave,
`endif
    ahb_interconnect_decoder_if.slave bus
);
    localparam logic [SEL_W-1:0] DEFAULT = SEL_W'(NUM_SLAVES);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t             ds_state, ds_next;
    logic [SEL_W-1:0]      dec_idx, dp_sel;
    logic                  dec_hit, dp_act;
    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  mux_ready, mux_resp;
    logic [DATA_WIDTH-1:0] mux_rdata;
    logic                  timeout_hit;
    logic                  unused_htrans0;

    assign unused_htrans0 = bus.htrans[0];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_idx    = DEFAULT;
        dec_hit    = 1'b0;
        dec_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.haddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec_idx       = SEL_W'(i);
                dec_hit       = 1'b1;
                dec_onehot    = '0;
                dec_onehot[i] = 1'b1;
            end
        end
    end

    assign bus.hselx = dec_onehot;

    always_comb begin
        mux_ready = 1'b1;
        mux_resp  = 1'b0;
        mux_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dp_sel == SEL_W'(i)) begin
                mux_ready = bus.hreadyout_s[i];
                mux_resp  = bus.hresp_s[i];
                mux_rdata = bus.hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Error states win over the owning slave so a timed-out slave is overridden.
    always_comb begin
        bus.hready = mux_ready;
        bus.hresp  = mux_resp;
        bus.hrdata = mux_rdata;
        case (ds_state)
            DS_ERR1: begin bus.hready = 1'b0; bus.hresp = 1'b1; bus.hrdata = '0; end
            DS_ERR2: begin bus.hready = 1'b1; bus.hresp = 1'b1; bus.hrdata = '0; end
            default: ;
        endcase
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if ((bus.hready && bus.htrans[1] && !dec_hit) || timeout_hit) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = (bus.htrans[1] && !dec_hit) ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ds_state <= DS_IDLE;
            dp_sel   <= DEFAULT;
            dp_act   <= 1'b0;
        end else begin
            ds_state <= ds_next;
            if (bus.hready) begin
                dp_sel <= dec_idx;
                dp_act <= bus.htrans[1];
            end
        end
    end

`ifdef AHB_INTERCONNECT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] t_cnt;
    logic             stall;

    // mux_ready is 1 for the default owner, so this only counts real slave waits.
    assign stall       = dp_act && !mux_ready && (ds_state == DS_IDLE);
    assign timeout_hit = stall && (t_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            t_cnt         <= '0;
            timeout_flag  <= 1'b0;
            timeout_slave <= '0;
        end else begin
            if (bus.hready || !stall) t_cnt <= '0;
            else if (!timeout_hit)    t_cnt <= t_cnt + 1'b1;
            if (timeout_hit) begin
                t_cnt         <= '0;
                timeout_flag  <= 1'b1;
                timeout_slave <= dp_sel;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_interconnect_decoder.sv
// tb/tb_ahb_interconnect_decoder.sv - directed self-checking bench for ahb_interconnect_decoder
module tb_ahb_interconnect_decoder;
    logic hclk = 1'b0;
    logic hresetn;
    int   checks = 0;
    int   errors = 0;

    always #5 hclk = ~hclk;

    ahb_interconnect_decoder_if #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    ahb_interconnect_decoder_if #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

`ifdef AHB_INTERCONNECT_TIMEOUT_EN
    logic       timeout_flag, timeout_flag2;
    logic [2:0] timeout_slave, timeout_slave2;
`endif

    ahb_interconnect_decoder #(.TIMEOUT_CYCLES(8)) dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
`ifdef AHB_INTERCONNECT_TIMEOUT_EN
        .timeout_flag  (timeout_flag),
        .timeout_slave (timeout_slave),
`endif
        .bus           (bus.slave)
    );

    ahb_interconnect_decoder #(
        .SLAVE_BASE({32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000})
    ) dut_overlap (
        .hclk          (hclk),
        .hresetn       (hresetn),
`ifdef AHB_INTERCONNECT_TIMEOUT_EN
        .timeout_flag  (timeout_flag2),
        .timeout_slave (timeout_slave2),
`endif
        .bus           (bus2.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #2;
    endtask

    initial begin
        hresetn          = 1'b0;
        bus.haddr        = 32'h8000_0000;
        bus.htrans       = 2'b00;
        bus.hreadyout_s  = 4'hF;
        bus.hresp_s      = 4'h0;
        bus.hrdata_s     = '0;
        bus2.haddr       = 32'h0;
        bus2.htrans      = 2'b00;
        bus2.hreadyout_s = 4'hF;
        bus2.hresp_s     = 4'h0;
        bus2.hrdata_s    = '0;

        tick(); tick();
        #1;
        check("rst_hready", {31'd0, bus.hready}, 32'd1);
        check("rst_hresp",  {31'd0, bus.hresp},  32'd0);
        check("rst_hrdata", bus.hrdata,          32'd0);
        check("rst_hselx",  {28'd0, bus.hselx},  32'd0);
`ifdef AHB_INTERCONNECT_TIMEOUT_EN
        check("rst_tflag",  {31'd0, timeout_flag}, 32'd0);
`endif
        hresetn = 1'b1;

        // Slave 2 read with two wait states
        tick();
        bus.haddr = 32'h2000_0010; bus.htrans = 2'b10;
        #1;
        check("s2_hselx",   {28'd0, bus.hselx}, 32'b0100);
        check("s2_aphase_ready", {31'd0, bus.hready}, 32'd1);
        tick();
        bus.haddr = 32'h0; bus.htrans = 2'b00; bus.hreadyout_s = 4'b1011;
        #1;
        check("s2_wait1",   {31'd0, bus.hready}, 32'd0);
        tick();
        #1;
        check("s2_wait2",   {31'd0, bus.hready}, 32'd0);
        tick();
        bus.hreadyout_s = 4'hF; bus.hrdata_s[64 +: 32] = 32'hDEAD_BEEF;
        #1;
        check("s2_ready",   {31'd0, bus.hready}, 32'd1);
        check("s2_hrdata",  bus.hrdata,          32'hDEAD_BEEF);
        check("s2_hresp",   {31'd0, bus.hresp},  32'd0);

        // Unmapped NONSEQ: two-cycle ERROR, then IDLE gets zero-wait OKAY
        tick();
        bus.haddr = 32'h8000_0000; bus.htrans = 2'b10;
        #1;
        check("um_hselx",   {28'd0, bus.hselx}, 32'd0);
        tick();
        bus.htrans = 2'b00;
        #1;
        check("err1_hready", {31'd0, bus.hready}, 32'd0);
        check("err1_hresp",  {31'd0, bus.hresp},  32'd1);
        check("err1_hrdata", bus.hrdata,          32'd0);
        tick();
        #1;
        check("err2_hready", {31'd0, bus.hready}, 32'd1);
        check("err2_hresp",  {31'd0, bus.hresp},  32'd1);
        tick();
        #1;
        check("idle_um_hready", {31'd0, bus.hready}, 32'd1);
        check("idle_um_hresp",  {31'd0, bus.hresp},  32'd0);

        // Back-to-back slave 0 then slave 1
        bus.hrdata_s[0 +: 32]  = 32'h11;
        bus.hrdata_s[32 +: 32] = 32'h22;
        bus.haddr = 32'h0000_0000; bus.htrans = 2'b10;
        tick();
        bus.haddr = 32'h1000_0004; bus.htrans = 2'b10;
        #1;
        check("b2b_hselx1", {28'd0, bus.hselx}, 32'b0010);
        check("b2b_ready0", {31'd0, bus.hready}, 32'd1);
        check("b2b_rdata0", bus.hrdata,          32'h11);
        tick();
        bus.haddr = 32'h8000_0000; bus.htrans = 2'b00;
        #1;
        check("b2b_ready1", {31'd0, bus.hready}, 32'd1);
        check("b2b_rdata1", bus.hrdata,          32'h22);
        tick();
        #1;
        check("dflt_hrdata", bus.hrdata, 32'd0);

        // Overlapping map: lowest index wins
        bus2.haddr = 32'h0000_0004;
        #1;
        check("ovl_hselx0", {28'd0, bus2.hselx}, 32'b0001);
        bus2.haddr = 32'h3000_0000;
        #1;
        check("ovl_hselx3", {28'd0, bus2.hselx}, 32'b1000);

`ifdef AHB_INTERCONNECT_TIMEOUT_EN
        // Slave 3 stalls forever: 8 wait cycles, then interconnect ERROR
        tick();
        bus.haddr = 32'h3000_0000; bus.htrans = 2'b10;
        #1;
        check("to_hselx", {28'd0, bus.hselx}, 32'b1000);
        tick();
        bus.haddr = 32'h0; bus.htrans = 2'b00; bus.hreadyout_s = 4'b0111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("to_wait%0d", k), {30'd0, bus.hready, bus.hresp}, 32'b00);
            tick();
        end
        #1;
        check("to_err1",   {30'd0, bus.hready, bus.hresp}, 32'b01);
        check("to_flag",   {31'd0, timeout_flag},          32'd1);
        check("to_slave",  {29'd0, timeout_slave},         32'd3);
        tick();
        #1;
        check("to_err2",   {30'd0, bus.hready, bus.hresp}, 32'b11);
        tick();
        #1;
        check("to_after",  {30'd0, bus.hready, bus.hresp}, 32'b10);
        check("to_sticky", {31'd0, timeout_flag},          32'd1);
        bus.hreadyout_s = 4'hF;
        hresetn = 1'b0;
        #1;
        check("to_clear",  {31'd0, timeout_flag},          32'd0);
        hresetn = 1'b1;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_interconnect_decoder.md
Name: ahb_interconnect_decoder

Overview:
- Parametrised AHB single-master to NUM_SLAVES-slave interconnect. It is the next generation of the slave-side interconnect interface and adds decode, a response multiplexer and a built-in default slave.
- Decodes haddr into one-hot hselx, registers the data-phase owner, and muxes hreadyout/hrdata/hresp back to the master.
- For unmapped addresses, generates the two-cycle AHB ERROR response itself.
- Sits between the master-side and slave-side interface bundles in the hdlTop fabric.

Parameters:
- NUM_SLAVES, 4, number of downstream slaves (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SLAVE_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slice i = slave i
- SLAVE_MASK, {4{32'hF000_0000}}, packed per-slave compare mask
- TIMEOUT_CYCLES, 256, wait-state limit; used only with the optional feature

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- haddr  in  ADDR_WIDTH  master address
- htrans  in  2  master transfer type
- hselx  out  NUM_SLAVES  one-hot slave select, address phase
- hready  out  1  hready to master and all slaves
- hreadyout_s  in  NUM_SLAVES  per-slave hreadyout
- hresp_s  in  NUM_SLAVES  per-slave hresp
- hrdata_s  in  NUM_SLAVES*DATA_WIDTH  packed per-slave read data
- hrdata  out  DATA_WIDTH  muxed read data to master
- hresp  out  1  muxed response to master (0 OKAY, 1 ERROR)
- timeout_flag  out  1  sticky timeout indicator (macro only)
- timeout_slave  out  $clog2(NUM_SLAVES)+1  index of the timed-out slave (macro only)

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low. Clock port is hclk, reset port is hresetn.
- Decode (combinational):
  - match[i] = ((haddr & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i])).
  - The lowest matching index wins; hselx is always one-hot or zero.
  - No match = default slave, hselx = 0.
  - Decode is independent of htrans; slaves qualify hselx with htrans.
- Data-phase registers update only when hready==1:
  - dp_sel <= decoded index, or DEFAULT (= NUM_SLAVES) when there is no match.
  - dp_act <= htrans[1] (NONSEQ/SEQ).
  - Reset: dp_sel=DEFAULT, dp_act=0.
- Output mux:
  - dp_sel<NUM_SLAVES: hready=hreadyout_s[dp_sel], hresp=hresp_s[dp_sel], hrdata=hrdata_s slice dp_sel. The slave's response passes through even when dp_act=0.
  - dp_sel==DEFAULT: outputs come from the default-slave FSM; hrdata=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: hready=1, hresp=0. Enter DS_ERR1 when hready && htrans[1] && no match.
  - DS_ERR1: hready=0, hresp=1. Always go to DS_ERR2.
  - DS_ERR2: hready=1, hresp=1. Go to DS_ERR1 if a new unmapped NONSEQ/SEQ is sampled, else DS_IDLE.
  - IDLE/BUSY to an unmapped address gets a zero-wait OKAY.
- Latency: decode has 0 cycles; data-phase ownership switches on the hready==1 edge, with no added wait states.
- Back-to-back transfers to different slaves are muxed seamlessly; the new owner takes effect the cycle after the hready-high sample.
- Reset: hready=1, hresp=0, hrdata=0, FSM=DS_IDLE, regardless of any transfer in flight. A slave stalled mid-transfer is abandoned.
- NUM_SLAVES=1: decode still applies; the default slave remains active.

Optional Feature:
- Macro: AHB_INTERCONNECT_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive cycles with dp_act=1, dp_sel<NUM_SLAVES and hreadyout_s[dp_sel]==0.
  - When the count reaches TIMEOUT_CYCLES, the interconnect overrides the slave and drives the DS_ERR1/DS_ERR2 two-cycle ERROR.
  - It sets timeout_flag=1 (sticky until reset) and latches timeout_slave=dp_sel.
  - The counter clears whenever hready=1.
- Undefined: no counter; timeout ports are absent; slave wait states are unbounded.

Test Plan:
- Reset with hresetn=0, then release: hready=1, hresp=0, hrdata=0, hselx=0 while haddr=0x8000_0000.
- NONSEQ read at 0x2000_0010, slave2 gives 2 wait states and then 0xDEAD_BEEF: hselx=4'b0100; master sees hready low for 2 cycles, then hrdata=0xDEAD_BEEF with OKAY.
- NONSEQ to 0x8000_0000: hselx=0; the next cycle has hready=0 and hresp=1, then hready=1 and hresp=1; an IDLE to the same address gets zero-wait OKAY.
- Back-to-back NONSEQ to 0x0000_0000 then 0x1000_0004, slaves returning 0x11 then 0x22: consecutive data phases return 0x11 then 0x22 with no extra wait states.
- Overlap: SLAVE_BASE[1]=SLAVE_BASE[0]=0, access 0x0000_0004: hselx=4'b0001 (lowest index wins).
- With AHB_INTERCONNECT_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave3 holds hreadyout=0: after 8 wait cycles comes the two-cycle ERROR, timeout_flag=1 and timeout_slave=3; hresetn low clears the flag.
